// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit 7-segment scan controller.
// Segment patterns are active-low, ordered {a,b,c,d,e,f,g}.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

endpackage

// File: rtl/bcd7_decode.sv
// BCD nibble to active-low 7-segment pattern; non-BCD nibbles and the blank flag give all-off.
module bcd7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'd0:    pattern = SEG_0;
        4'd1:    pattern = SEG_1;
        4'd2:    pattern = SEG_2;
        4'd3:    pattern = SEG_3;
        4'd4:    pattern = SEG_4;
        4'd5:    pattern = SEG_5;
        4'd6:    pattern = SEG_6;
        4'd7:    pattern = SEG_7;
        4'd8:    pattern = SEG_8;
        4'd9:    pattern = SEG_9;
        default: pattern = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan of four BCD digits onto a common-anode display, with an all-off guard
// window at the start of each slot and a shadow register committed only at frame boundaries.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned SLOT_CYC  = 100000,
  parameter int unsigned BLANK_CYC = 16,
  parameter bit          LZ_BLANK  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done,
  output logic        pending
);

  localparam int unsigned CntW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(SLOT_CYC - 1);
  localparam logic [CntW-1:0] CntBlank = CntW'(BLANK_CYC);

  logic [CntW-1:0] cnt;
  logic [1:0]      idx;
  logic [15:0]     shadow;
  logic [3:0]      shadow_dp;
  logic [15:0]     active;
  logic [3:0]      active_dp;

  logic            cnt_last;
  logic            commit;
  logic            in_guard;
  logic [3:0]      cur_nib;
  logic [3:0]      lz_mask;
  logic [6:0]      dec_seg;
  logic [15:0]     next_active;
  logic [3:0]      next_active_dp;

  assign cnt_last = (cnt == CntLast);
  assign commit   = enable && cnt_last && (idx == 2'd3);
  assign in_guard = (cnt < CntBlank);
  assign cur_nib  = active[{idx, 2'b00} +: 4];

  // A write landing on the commit cycle bypasses the shadow so it is not lost.
  assign next_active    = wr_en ? wr_data : shadow;
  assign next_active_dp = wr_en ? dp_in : shadow_dp;

  // Digit i is blanked when it and every more-significant digit are zero.
  always_comb begin
    lz_mask    = 4'b0000;
    lz_mask[3] = (active[15:12] == 4'd0);
    lz_mask[2] = lz_mask[3] && (active[11:8] == 4'd0);
    lz_mask[1] = lz_mask[2] && (active[7:4] == 4'd0);
    if (!LZ_BLANK) begin
      lz_mask = 4'b0000;
    end
  end

  bcd7_decode u_decode (
    .nibble  (cur_nib),
    .blank   (lz_mask[idx]),
    .pattern (dec_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= 2'd0;
      shadow     <= 16'h0000;
      shadow_dp  <= 4'h0;
      active     <= 16'h0000;
      active_dp  <= 4'h0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      an         <= AN_OFF;
    end else begin
      if (wr_en) begin
        shadow    <= wr_data;
        shadow_dp <= dp_in;
      end

      if (!enable) begin
        cnt        <= '0;
        idx        <= 2'd0;
        active     <= next_active;
        active_dp  <= next_active_dp;
        pending    <= 1'b0;
        frame_done <= 1'b0;
        seg        <= SEG_BLANK;
        dp         <= 1'b1;
        an         <= AN_OFF;
      end else begin
        if (cnt_last) begin
          cnt <= '0;
          idx <= idx + 2'd1;
        end else begin
          cnt <= cnt + CntW'(1);
        end

        frame_done <= commit;
        if (commit) begin
          active    <= next_active;
          active_dp <= next_active_dp;
          pending   <= 1'b0;
        end else if (wr_en) begin
          pending <= 1'b1;
        end

        if (in_guard) begin
          seg <= SEG_BLANK;
          dp  <= 1'b1;
          an  <= AN_OFF;
        end else begin
          seg <= dec_seg;
          dp  <= ~active_dp[idx];
          an  <= ~(4'b0001 << idx);
        end
      end
    end
  end

endmodule
